// File: rtl/nou_rx_pkt_buffer.sv
// nou_rx_pkt_buffer: NoC receive front end; captures the descriptor flit into packet fields, buffers payload in a show-ahead FIFO, holds off the next packet until write done/error (ports: noc flit in, start_aw + pkt fields out, pb_* FIFO read port, wr_done/wr_err in, pkt_done/pkt_err pulses out)
`ifndef NOU_NOC_DATA_WIDTH
`define NOU_NOC_DATA_WIDTH 64
`endif
`ifndef NOU_PKT_HEADER_ADDR_WIDTH
`define NOU_PKT_HEADER_ADDR_WIDTH 22
`endif
`ifndef NOU_PKT_HEADER_SZ_WIDTH
`define NOU_PKT_HEADER_SZ_WIDTH 12
`endif
`ifndef NOU_PKT_DATA_ADDR_WIDTH
`define NOU_PKT_DATA_ADDR_WIDTH 22
`endif
`ifndef NOU_PKT_DATA_SZ_WIDTH
`define NOU_PKT_DATA_SZ_WIDTH 8
`endif
module nou_rx_pkt_buffer #(
  parameter int DEPTH = 16
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  noc_flit_vld,
  output logic                                  noc_flit_rdy,
  input  logic [`NOU_NOC_DATA_WIDTH-1:0]        noc_flit_data,
  output logic                                  start_aw,
  output logic [`NOU_PKT_HEADER_ADDR_WIDTH-1:0] pkt_header_addr,
  output logic [`NOU_PKT_HEADER_SZ_WIDTH-1:0]   pkt_header_sz,
  output logic [`NOU_PKT_DATA_ADDR_WIDTH-1:0]   pkt_data_addr,
  output logic [`NOU_PKT_DATA_SZ_WIDTH-1:0]     pkt_data_sz,
  output logic                                  pb_empty,
  output logic [`NOU_NOC_DATA_WIDTH-1:0]        data_flit,
  input  logic                                  pb_rd_en,
  input  logic                                  wr_done,
  input  logic                                  wr_err,
  output logic                                  pkt_done,
  output logic                                  pkt_err
);
  localparam int AW  = $clog2(DEPTH);
  localparam int HAW = `NOU_PKT_HEADER_ADDR_WIDTH;
  localparam int HSW = `NOU_PKT_HEADER_SZ_WIDTH;
  localparam int DAW = `NOU_PKT_DATA_ADDR_WIDTH;
  localparam int DSW = `NOU_PKT_DATA_SZ_WIDTH;
  localparam int CW  = DSW + 5;
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, WAIT = 2'd2;
  logic [1:0] state_q, state_d;
  logic alive_q;
  logic [CW-1:0] rem_q, rem_d, total;
  logic [AW:0] count_q;
  logic [AW-1:0] wp_q, rp_q;
  logic [`NOU_NOC_DATA_WIDTH-1:0] mem [DEPTH];
  logic [HAW-1:0] d_haddr;
  logic [HSW-1:0] d_hsz;
  logic [DAW-1:0] d_daddr;
  logic [DSW-1:0] d_dsz;
  logic accept, desc, push, pop;
  assign d_haddr = noc_flit_data[HAW-1:0];
  assign d_hsz   = noc_flit_data[HAW +: HSW];
  assign d_daddr = noc_flit_data[HAW+HSW +: DAW];
  assign d_dsz   = noc_flit_data[HAW+HSW+DAW +: DSW];
  assign total = ((CW'(d_hsz) + CW'(64)) >> 6) + ((CW'(d_dsz) + CW'(1)) << 4);
  // alive_q keeps rdy low while in reset and until the first clock after release
  assign noc_flit_rdy = alive_q & ((state_q == IDLE) | ((state_q == LOAD) & ~count_q[AW]));
  assign pb_empty  = count_q == '0;
  assign data_flit = pb_empty ? '0 : mem[rp_q];
  assign accept = noc_flit_vld & noc_flit_rdy;
  assign desc   = accept & (state_q == IDLE);
  assign push   = accept & (state_q == LOAD);
  assign pop    = pb_rd_en & ~pb_empty;
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (desc) begin
      state_d = LOAD;
      rem_d   = total;
    end else if (push) begin
      rem_d   = rem_q - CW'(1);
      state_d = rem_q == CW'(1) ? WAIT : LOAD;
    end else if (state_q == WAIT && (wr_err || wr_done)) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= IDLE;
      alive_q         <= 1'b0;
      rem_q           <= '0;
      count_q         <= '0;
      wp_q            <= '0;
      rp_q            <= '0;
      start_aw        <= 1'b0;
      pkt_done        <= 1'b0;
      pkt_err         <= 1'b0;
      pkt_header_addr <= '0;
      pkt_header_sz   <= '0;
      pkt_data_addr   <= '0;
      pkt_data_sz     <= '0;
    end else begin
      state_q  <= state_d;
      alive_q  <= 1'b1;
      rem_q    <= rem_d;
      count_q  <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      wp_q     <= wp_q + AW'(push);
      rp_q     <= rp_q + AW'(pop);
      start_aw <= desc;
      pkt_err  <= (state_q == WAIT) & wr_err;
      pkt_done <= (state_q == WAIT) & wr_done & ~wr_err;
      if (desc) begin
        pkt_header_addr <= d_haddr;
        pkt_header_sz   <= d_hsz;
        pkt_data_addr   <= d_daddr;
        pkt_data_sz     <= d_dsz;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wp_q] <= noc_flit_data;
  end
endmodule

// File: tb/tb_nou_rx_pkt_buffer.sv
// tb_nou_rx_pkt_buffer: randomized scoreboard bench for nou_rx_pkt_buffer against a packet-level queue model
`ifndef NOU_NOC_DATA_WIDTH
`define NOU_NOC_DATA_WIDTH 64
`endif
`ifndef NOU_PKT_HEADER_ADDR_WIDTH
`define NOU_PKT_HEADER_ADDR_WIDTH 22
`endif
`ifndef NOU_PKT_HEADER_SZ_WIDTH
`define NOU_PKT_HEADER_SZ_WIDTH 12
`endif
`ifndef NOU_PKT_DATA_ADDR_WIDTH
`define NOU_PKT_DATA_ADDR_WIDTH 22
`endif
`ifndef NOU_PKT_DATA_SZ_WIDTH
`define NOU_PKT_DATA_SZ_WIDTH 8
`endif
module tb_nou_rx_pkt_buffer;
  localparam int DEPTH = 16;
  logic clk = 0, rstn = 0;
  logic noc_flit_vld = 0, noc_flit_rdy;
  logic [63:0] noc_flit_data = '0;
  logic start_aw, pb_empty, pb_rd_en = 0, wr_done = 0, wr_err = 0, pkt_done, pkt_err;
  logic [21:0] pkt_header_addr, pkt_data_addr;
  logic [11:0] pkt_header_sz;
  logic [7:0] pkt_data_sz;
  logic [63:0] data_flit;
  int tests = 0, fails = 0, pop_pct = 50;
  nou_rx_pkt_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .noc_flit_vld(noc_flit_vld), .noc_flit_rdy(noc_flit_rdy),
    .noc_flit_data(noc_flit_data), .start_aw(start_aw), .pkt_header_addr(pkt_header_addr),
    .pkt_header_sz(pkt_header_sz), .pkt_data_addr(pkt_data_addr), .pkt_data_sz(pkt_data_sz),
    .pb_empty(pb_empty), .data_flit(data_flit), .pb_rd_en(pb_rd_en), .wr_done(wr_done),
    .wr_err(wr_err), .pkt_done(pkt_done), .pkt_err(pkt_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask
  // Reference model: phase of the current packet, flits still owed, expected FIFO contents
  logic [63:0] q[$];
  int ph = 0, rem = 0;
  bit alive = 0, e_start = 0, e_done = 0, e_err = 0, e_rdy;
  logic [21:0] e_ha = '0, e_da = '0;
  logic [11:0] e_hs = '0;
  logic [7:0] e_ds = '0;
  always @(negedge clk) begin
    if (!rstn) begin
      chk("rst_rdy", 64'(noc_flit_rdy), 64'(0));
      chk("rst_start", 64'(start_aw), 64'(0));
      chk("rst_empty", 64'(pb_empty), 64'(1));
      chk("rst_data", data_flit, 64'(0));
      chk("rst_done_err", 64'({pkt_done, pkt_err}), 64'(0));
      chk("rst_fields", 64'({pkt_header_addr, pkt_header_sz, pkt_data_addr, pkt_data_sz}), 64'(0));
      q.delete();
      ph = 0; rem = 0; alive = 0; e_start = 0; e_done = 0; e_err = 0;
      e_ha = '0; e_hs = '0; e_da = '0; e_ds = '0;
    end else begin
      e_rdy = alive && (ph == 0 || (ph == 1 && q.size() < DEPTH));
      chk("rdy", 64'(noc_flit_rdy), 64'(e_rdy));
      chk("start_aw", 64'(start_aw), 64'(e_start));
      chk("fields", 64'({pkt_header_addr, pkt_header_sz, pkt_data_addr, pkt_data_sz}),
          64'({e_ha, e_hs, e_da, e_ds}));
      chk("pb_empty", 64'(pb_empty), 64'(q.size() == 0));
      if (q.size() != 0) chk("data_flit", data_flit, q[0]);
      chk("pkt_done", 64'(pkt_done), 64'(e_done));
      chk("pkt_err", 64'(pkt_err), 64'(e_err));
      e_start = 0; e_done = 0; e_err = 0;
      if (pb_rd_en && q.size() != 0) void'(q.pop_front());
      if (noc_flit_vld && e_rdy) begin
        if (ph == 0) begin
          e_ha = noc_flit_data[21:0]; e_hs = noc_flit_data[33:22];
          e_da = noc_flit_data[55:34]; e_ds = noc_flit_data[63:56];
          rem = ((int'(e_hs) + 64) >> 6) + ((int'(e_ds) + 1) << 4);
          e_start = 1; ph = 1;
        end else begin
          q.push_back(noc_flit_data);
          rem--;
          if (rem == 0) ph = 2;
        end
      end else if (ph == 2 && wr_err) begin
        e_err = 1; ph = 0;
      end else if (ph == 2 && wr_done) begin
        e_done = 1; ph = 0;
      end
      alive = 1;
    end
  end
  always @(posedge clk) begin
    #2 pb_rd_en = $urandom_range(99) < pop_pct;
  end
  task automatic send_pkt(input int hs, input int ds, input int lim, input bit stray);
    int tot, units, sent = 0, n = 0;
    tot = ((hs + 64) >> 6) + ((ds + 1) << 4);
    units = 1 + (lim < tot ? lim : tot);
    noc_flit_vld = 1;
    noc_flit_data = {8'(ds), 22'($urandom), 12'(hs), 22'($urandom)};
    while (sent < units && n < 3000) begin
      @(negedge clk);
      n++;
      if (noc_flit_vld && noc_flit_rdy) sent++;
      @(posedge clk); #1;
      wr_done = stray && sent == 4;
      noc_flit_vld = sent < units && $urandom_range(3) != 0;
      noc_flit_data = {$urandom, $urandom};
    end
    noc_flit_vld = 0;
    wr_done = 0;
    tests++;
    if (sent != units) begin
      fails++;
      $display("FAIL send_timeout: sent %0d flits, required %0d", sent, units);
    end
  endtask
  task automatic end_pkt(input bit d, input bit e);
    repeat ($urandom_range(1, 4)) @(posedge clk);
    #1 wr_done = d; wr_err = e;
    @(posedge clk); #1 wr_done = 0; wr_err = 0;
    repeat (2) @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 rstn = 1;
    repeat (2) @(posedge clk);
    #1;
    send_pkt(12'h3F, 0, 1000, 0);
    end_pkt(1, 0);
    fork
      send_pkt(12'h3F, 0, 1000, 0);
      begin
        pop_pct = 0;
        repeat (40) @(posedge clk);
        #3 pop_pct = 100;
        @(posedge clk); #3 pop_pct = 0;
        repeat (20) @(posedge clk);
        #3 pop_pct = 60;
      end
    join
    end_pkt(1, 0);
    pop_pct = 100;
    send_pkt(12'h010, 1, 1000, 1);
    end_pkt(1, 1);
    pop_pct = 30;
    send_pkt(12'h080, 2, 1000, 0);
    end_pkt(0, 1);
    send_pkt(12'h3F, 0, 5, 0);
    #1 rstn = 0;
    repeat (2) @(posedge clk);
    #1 rstn = 1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      pop_pct = $urandom_range(20, 100);
      send_pkt($urandom_range(0, 300), $urandom_range(0, 1), 1000, $urandom_range(1));
      end_pkt($urandom_range(1), $urandom_range(1));
      if (!(wr_done || wr_err)) end_pkt(1, 0);
    end
    pop_pct = 100;
    repeat (60) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
